// File: rtl/day_pkg.sv
// Shared types and constants for the day counter family: state encoding,
// seven-segment table and BCD digit saturation.
package day_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}, dp always off.
  localparam logic [7:0] SEG_TABLE [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  function automatic logic [3:0] bcd_sat(input logic [3:0] digit);
    return (digit > 4'd9) ? 4'd9 : digit;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// BCD digit to active-low seven-segment pattern; combinational, no latency.
// No flow control; non-BCD codes render as blank.
module seg7_encode
  import day_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) begin
      seg = SEG_TABLE[bcd];
    end
  end

endmodule

// File: rtl/day_countdown.sv
// Two-digit BCD countdown, one decrement per CLK_DIV-cycle tick; HEX/LED0 registered (1-cycle lag).
// No backpressure: pause freezes prescaler and digits, load/start are sampled every edge.
module day_countdown
  import day_pkg::*;
#(
  parameter int CLK_DIV    = 10000000,
  parameter int START_TENS = 9,
  parameter int START_ONES = 9
) (
  input  logic       ADC_CLK_10,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic       LED0,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [7:0] HEX3,
  output logic [7:0] HEX4,
  output logic [7:0] HEX5
);

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [3:0] START_T = (START_TENS > 9) ? 4'd9 : 4'(START_TENS);
  localparam logic [3:0] START_O = (START_ONES > 9) ? 4'd9 : 4'(START_ONES);

  state_t        state;
  logic [3:0]    tens;
  logic [3:0]    ones;
  logic [PW-1:0] presc;

  logic          tick;
  logic          count_zero;
  logic [3:0]    dec_tens;
  logic [3:0]    dec_ones;
  logic          dec_zero;
  logic [3:0]    disp_tens;
  logic [3:0]    disp_ones;
  logic [7:0]    seg_tens;
  logic [7:0]    seg_ones;

  always_comb begin
    tick       = (state == RUN) && !pause && (presc == PRESC_MAX);
    count_zero = (tens == 4'd0) && (ones == 4'd0);
    dec_ones   = (ones == 4'd0) ? 4'd9 : ones - 4'd1;
    dec_tens   = (ones == 4'd0) ? tens - 4'd1 : tens;
    dec_zero   = (dec_tens == 4'd0) && (dec_ones == 4'd0);
  end

  // During reset the encoders see the start digits so the display reloads on the same edge.
  always_comb begin
    disp_tens = reset ? START_T : tens;
    disp_ones = reset ? START_O : ones;
  end

  seg7_encode u_enc_tens (
    .bcd (disp_tens),
    .seg (seg_tens)
  );

  seg7_encode u_enc_ones (
    .bcd (disp_ones),
    .seg (seg_ones)
  );

  always_ff @(posedge ADC_CLK_10) begin
    HEX5 <= seg_tens;
    HEX4 <= seg_ones;
    if (reset) begin
      state <= IDLE;
      tens  <= START_T;
      ones  <= START_O;
      presc <= '0;
      LED0  <= 1'b0;
    end else begin
      LED0 <= (state == DONE);
      if (load) begin
        tens  <= bcd_sat(load_tens);
        ones  <= bcd_sat(load_ones);
        presc <= '0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            presc <= '0;
            if (start) begin
              state <= count_zero ? DONE : RUN;
            end
          end
          RUN: begin
            if (tick) begin
              presc <= '0;
              tens  <= dec_tens;
              ones  <= dec_ones;
              if (dec_zero) begin
                state <= DONE;
              end
            end else if (!pause) begin
              presc <= presc + PW'(1);
            end
          end
          DONE: begin
            presc <= '0;
          end
          default: begin
            state <= IDLE;
            presc <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    HEX0 = SEG_BLANK;
    HEX1 = SEG_BLANK;
    HEX2 = SEG_BLANK;
    HEX3 = SEG_BLANK;
  end

endmodule

// File: tb/tb_day_countdown.sv
// Bench for day_countdown: integer-valued countdown model checked every cycle,
// plus literal spot checks of the directed scenarios and a random phase.
module tb_day_countdown;

  localparam int CLK_DIV = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] load_ones = 4'd0;
  logic       led0;
  logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;

  int tests = 0;
  int fails = 0;

  // Model state: count as a plain 0..99 integer.
  int m_cnt = 99;
  int m_mode = M_IDLE;
  int m_presc = 0;
  int exp_val = 99;
  bit exp_led = 1'b0;
  bit valid = 1'b0;

  day_countdown #(.CLK_DIV(CLK_DIV), .START_TENS(9), .START_ONES(9)) dut (
    .ADC_CLK_10 (clk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .load       (load),
    .load_tens  (load_tens),
    .load_ones  (load_ones),
    .LED0       (led0),
    .HEX0       (hex0),
    .HEX1       (hex1),
    .HEX2       (hex2),
    .HEX3       (hex3),
    .HEX4       (hex4),
    .HEX5       (hex5)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int sat(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advance on each rising edge from the sampled inputs.
  always @(posedge clk) begin
    if (reset) begin
      exp_val = 99;
      exp_led = 1'b0;
      m_cnt   = 99;
      m_mode  = M_IDLE;
      m_presc = 0;
      valid   = 1'b1;
    end else begin
      exp_val = m_cnt;
      exp_led = (m_mode == M_DONE);
      if (load) begin
        m_cnt   = sat(load_tens) * 10 + sat(load_ones);
        m_mode  = M_IDLE;
        m_presc = 0;
      end else if (m_mode == M_IDLE) begin
        if (start) begin
          m_mode  = (m_cnt == 0) ? M_DONE : M_RUN;
          m_presc = 0;
        end
      end else if (m_mode == M_RUN && !pause) begin
        if (m_presc == CLK_DIV - 1) begin
          m_presc = 0;
          m_cnt   = m_cnt - 1;
          if (m_cnt == 0) m_mode = M_DONE;
        end else begin
          m_presc = m_presc + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      check("hex5", {24'd0, hex5}, {24'd0, enc(exp_val / 10)});
      check("hex4", {24'd0, hex4}, {24'd0, enc(exp_val % 10)});
      check("led0", {31'd0, led0}, {31'd0, exp_led});
      check("hex3_0", {hex3, hex2, hex1, hex0}, 32'hFFFF_FFFF);
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit(input string name, input logic [7:0] h5, input logic [7:0] h4, input logic l);
    check({name, "_hex5"}, {24'd0, hex5}, {24'd0, h5});
    check({name, "_hex4"}, {24'd0, hex4}, {24'd0, h4});
    check({name, "_led0"}, {31'd0, led0}, {31'd0, l});
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    load = 1'b1; load_tens = t; load_ones = o;
    cycles(1);
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  initial begin
    // Reset and idle hold.
    cycles(2);
    lit("reset", 8'h90, 8'h90, 1'b0);
    check("reset_blank", {hex3, hex2, hex1, hex0}, 32'hFFFF_FFFF);
    reset = 1'b0;
    cycles(20);
    lit("idle20", 8'h90, 8'h90, 1'b0);

    // Run: first tick 4 edges after start, display one edge later.
    pulse_start();
    cycles(4);
    lit("run_lag", 8'h90, 8'h90, 1'b0);
    cycles(1);
    lit("run_98", 8'h90, 8'h80, 1'b0);
    cycles(36);
    lit("run_89", 8'h80, 8'h90, 1'b0);

    // Count down 02 to DONE.
    do_load(4'd0, 4'd2);
    pulse_start();
    cycles(4);
    lit("cd_02", 8'hC0, 8'hA4, 1'b0);
    cycles(1);
    lit("cd_01", 8'hC0, 8'hF9, 1'b0);
    cycles(3);
    lit("cd_pre", 8'hC0, 8'hF9, 1'b0);
    cycles(1);
    lit("cd_00", 8'hC0, 8'hC0, 1'b1);
    pulse_start();
    cycles(3);
    pulse_start();
    lit("done_hold", 8'hC0, 8'hC0, 1'b1);

    // Pause mid-period with the prescaler at 2.
    do_load(4'd5, 4'd0);
    pulse_start();
    cycles(2);
    pause = 1'b1;
    cycles(10);
    lit("paused", 8'h92, 8'hC0, 1'b0);
    pause = 1'b0;
    cycles(2);
    lit("resume_lag", 8'h92, 8'hC0, 1'b0);
    cycles(1);
    lit("resume_49", 8'h99, 8'h90, 1'b0);

    // Load 00 then start: DONE immediately.
    do_load(4'd0, 4'd0);
    pulse_start();
    cycles(1);
    lit("zero_done", 8'hC0, 8'hC0, 1'b1);

    // Saturating load.
    do_load(4'hF, 4'hC);
    cycles(1);
    lit("sat_99", 8'h90, 8'h90, 1'b0);

    // Reset on a tick cycle in RUN.
    do_load(4'd4, 4'd5);
    pulse_start();
    cycles(3);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    lit("rst_tick", 8'h90, 8'h90, 1'b0);
    cycles(10);
    lit("rst_idle", 8'h90, 8'h90, 1'b0);

    // Load and start together: stays IDLE with loaded value.
    load = 1'b1; start = 1'b1; load_tens = 4'd3; load_ones = 4'd7;
    cycles(1);
    load = 1'b0; start = 1'b0;
    cycles(12);
    lit("load_start", 8'hB0, 8'hF8, 1'b0);

    // Random phase against the model.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      load      = ($urandom_range(0, 24) == 0);
      start     = ($urandom_range(0, 7) == 0);
      pause     = ($urandom_range(0, 3) == 0);
      load_tens = 4'($urandom_range(0, 15));
      load_ones = 4'($urandom_range(0, 15));
      cycles(1);
    end
    reset = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
